wide_word_serializer: RTL
=========================

# wide_word_serializer

Accepts one wide block (e.g. a 320-bit permutation state) over a valid/ready handshake. Stores it, then emits it as a sequence of WORD_WIDTH-bit words, word 0 (LSBs) first, over a second valid/ready handshake. It sits directly upstream of the word-slicing mux: it owns the buffer register and the word-index counter, and the mux (`select`) performs the slice.

## Interface
- `IN_WIDTH`, 320, width of the wide input block; must be an integer multiple of WORD_WIDTH.
- `WORD_WIDTH`, 32, width of each emitted word.
- Derived localparams:
  - `NWORDS = IN_WIDTH/WORD_WIDTH`
  - `IDX_W = $clog2(NWORDS)`, forced to a minimum of 1.
- `clk` input 1 — rising-edge clock.
- `reset` input 1 — reset, synchronous, active-high.
- `in_data` input IN_WIDTH — wide block to serialize.
- `in_valid` input 1 — in_data valid.
- `in_ready` output 1 — block can be accepted this cycle.
- `out_data` output WORD_WIDTH — current word.
- `out_valid` output 1 — out_data valid.
- `out_ready` input 1 — downstream accepts the word.
- `out_index` output IDX_W — index of the current word.
- `out_last` output 1 — current word is word NWORDS-1.
- `busy` output 1 — a block is held, i.e. not idle.

## Operation
- FSM states: S_IDLE, S_SEND.
- Registers: `buf` (IN_WIDTH), `idx` (IDX_W), `state`.
- **S_IDLE**
  - in_ready=1, out_valid=0.
  - On in_valid: buf<=in_data, idx<=0, go to S_SEND.
- **S_SEND**
  - out_valid=1.
  - out_data = buf[idx*WORD_WIDTH +: WORD_WIDTH], out_index=idx, out_last=(idx==NWORDS-1).
  - Word handshake: out_valid && out_ready.
    - Handshake with !out_last: idx<=idx+1.
    - Handshake with out_last and no new block: go to S_IDLE, idx<=0.
  - Simultaneous last-word handshake and new block:
    - in_ready = out_last && out_ready, combinational from out_ready.
    - When in_valid is also high: buf<=in_data, idx<=0, stay in S_SEND. There is no bubble between blocks.
  - in_ready=0 in S_SEND except in the last-word case above.
- Stall: while out_valid && !out_ready, out_data, out_index and out_last hold stable.
- idx never exceeds NWORDS-1; it does not wrap through unused codes, including the non-power-of-2 case NWORDS=10.
- When out_valid=0, out_data, out_index and out_last are driven 0.
- busy = (state==S_SEND).
- in_data is sampled only on an input handshake; changes at other times are ignored.

## Timing
- Reset values: state=S_IDLE, buf=0, idx=0. Resulting outputs: in_ready=1, out_valid=0, out_data=0, out_index=0, out_last=0, busy=0.
- Reset mid-operation discards the held block. No partial words are emitted after the reset cycle.
- Latency: input handshake at edge N → word 0 valid in cycle N+1.
- Throughput with out_ready held at 1: one word per cycle, NWORDS cycles per block when back-to-back.
- Combinational paths:
  - out_ready → in_ready (only this path).
  - All out_* signals come from registers through the slice mux.

## Structure
- Package `serializer_pkg`: typedef enum logic [0:0] `ser_state_t` {S_IDLE, S_SEND}.
- Sub-module: instance of `select`.
  - Parameters: INPUT_WIDTH=IN_WIDTH, OUT_WIDTH=WORD_WIDTH.
  - Connections: inputVal=buf, index=idx, reset=!busy. The mux then supplies the zeroed out_data when idle.
- The counter, FSM and handshake logic live in the top module.

## Test plan
Default parameters (320/32) unless stated.
- **Basic:** after reset, send in_data with word k = 32'hA000_0000+k; hold out_ready=1 → 10 consecutive words A0000000..A0000009, out_index 0..9, out_last only at 9, then out_valid=0 and in_ready=1.
- **Back-to-back:** in_valid held with a second block (words 32'hB000_0000+k) → word B0000000 appears in the cycle after A0000009 with no bubble, and in_ready pulses exactly once per block.
- **Backpressure:** hold out_ready=0 for 5 cycles while word 3 (A0000003) is presented → out_data, out_index=3 and out_last stay constant; resuming gives word 4 next.
- **Random stall:** out_ready driven by a random pattern → scoreboard sees every word exactly once, in order, with no duplicates.
- **Reset mid-block:** assert reset while word 5 is presented → the next cycle shows out_valid=0, out_data=0, busy=0, in_ready=1; a new block starts cleanly at word 0.
- **Narrow config:** IN_WIDTH=8, WORD_WIDTH=4, in_data=8'h5C → words 4'hC then 4'h5, with out_last on the second word.

Source files
------------

// File: rtl/serializer_pkg.sv
// serializer_pkg: shared state type for the wide word serializer.
package serializer_pkg;
    typedef enum logic [0:0] {S_IDLE, S_SEND} ser_state_t;
endpackage

// File: rtl/wide_word_serializer_select.sv
// select: word-slicing mux; drives zero while held in reset.
module select #(
    parameter int INPUT_WIDTH = 320,
    parameter int OUT_WIDTH = 32,
    localparam int NW = INPUT_WIDTH / OUT_WIDTH,
    localparam int IW = (NW > 1) ? $clog2(NW) : 1
) (
    input  logic [INPUT_WIDTH-1:0] inputVal,
    input  logic [IW-1:0]          index,
    input  logic                   reset,
    output logic [OUT_WIDTH-1:0]   outputVal
);
    always_comb begin
        outputVal = '0;
        if (!reset && int'(index) < NW)
            outputVal = inputVal[int'(index)*OUT_WIDTH +: OUT_WIDTH];
    end
endmodule

// File: rtl/wide_word_serializer.sv
// wide_word_serializer: buffers one wide block and emits it LSB word first.
module wide_word_serializer
    import serializer_pkg::*;
#(
    parameter int IN_WIDTH = 320,
    parameter int WORD_WIDTH = 32,
    localparam int NWORDS = IN_WIDTH / WORD_WIDTH,
    localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [IN_WIDTH-1:0]   in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WORD_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IDX_W-1:0]      out_index,
    output logic                  out_last,
    output logic                  busy
);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NWORDS - 1);

    ser_state_t          r_state;
    ser_state_t          w_next_state;
    logic [IN_WIDTH-1:0] r_buf;
    logic [IDX_W-1:0]    r_idx;
    logic                w_send;
    logic                w_last;
    logic                w_in_hs;
    logic                w_out_hs;

    assign w_send   = (r_state == S_SEND);
    assign w_last   = w_send && (r_idx == LAST);
    assign w_out_hs = w_send && out_ready;
    // A new block may enter only as the final word leaves, so no bubble appears.
    assign in_ready = !w_send || (w_last && out_ready);
    assign w_in_hs  = in_valid && in_ready;

    always_comb begin
        w_next_state = r_state;
        if (w_in_hs)
            w_next_state = S_SEND;
        else if (w_out_hs && w_last)
            w_next_state = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_buf   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_in_hs) begin
                r_buf <= in_data;
                r_idx <= '0;
            end else if (w_out_hs) begin
                r_idx <= w_last ? '0 : r_idx + 1'b1;
            end
        end
    end

    select #(
        .INPUT_WIDTH(IN_WIDTH),
        .OUT_WIDTH(WORD_WIDTH)
    ) u_select (
        .inputVal (r_buf),
        .index    (r_idx),
        .reset    (!busy),
        .outputVal(out_data)
    );

    assign out_valid = w_send;
    assign out_index = w_send ? r_idx : '0;
    assign out_last  = w_last;
    assign busy      = w_send;
endmodule
